// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Pipeline hazard controller. Detects load-use hazards in ID,  |
// |               taken BEQ branches resolved in EX and J instructions in ID,  |
// |               and drives the next-PC select controls together with the    |
// |               IF/ID flush and ID/EX bubble controls. Keeps multi-cycle     |
// |               stall/flush state and two saturating performance counters.  |
// |                                                                            |
// | Ports                                                                      |
// |   clk, rst_n        : clock (rising edge), asynchronous active-low reset   |
// |   id_rs, id_rt      : source register fields of the ID instruction        |
// |   id_use_rs/_rt     : ID instruction actually reads rs / rt                |
// |   ex_mem_read,ex_rt : EX instruction is a load, and its destination        |
// |   ex_beq, ex_zero   : EX instruction is BEQ, ALU zero flag                 |
// |   id_jump           : ID instruction is J                                  |
// |   cnt_clr           : synchronous clear of both performance counters       |
// |   pc_sub_4_data     : re-fetch current PC because of a data bubble         |
// |   pc_sub_4_ctrl     : re-fetch current PC because of a control bubble      |
// |   beq, jump         : select branch / jump target                          |
// |   if_id_flush       : zero the IF/ID register                              |
// |   id_ex_bubble      : inject a NOP into ID/EX                              |
// |   state             : RUN=0, LD_STALL=1, BR_FLUSH=2                        |
// |   stall_cnt         : cycles with either pc_sub_4 output high              |
// |   flush_cnt         : cycles with if_id_flush high                         |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int LD_EXTRA = 0,   // extra load-use stall cycles, 0..7
  parameter int BR_EXTRA = 1,   // extra flush cycles after a taken branch, 0..7
  parameter int CNT_W    = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_beq,
  input  logic             ex_zero,
  input  logic             id_jump,
  input  logic             cnt_clr,
  output logic             pc_sub_4_data,
  output logic             pc_sub_4_ctrl,
  output logic             beq,
  output logic             jump,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  // Reload values for the extra-cycle down-counter; only used when the
  // corresponding EXTRA parameter is non-zero.
  localparam logic [2:0]       c_LD_LOAD = (LD_EXTRA > 0) ? 3'(LD_EXTRA - 1) : 3'd0;
  localparam logic [2:0]       c_BR_LOAD = (BR_EXTRA > 0) ? 3'(BR_EXTRA - 1) : 3'd0;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MAX     = {CNT_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_nxt_state;
  logic [2:0]       w_nxt_cnt;
  logic             w_ld_haz;
  logic             w_br_tk;
  logic             w_psd;
  logic             w_psc;
  logic             w_beq;
  logic             w_jump;
  logic             w_flush;
  logic             w_bubble;
  logic             w_stall_inc;
  logic             w_flush_inc;

  // A load into $0 never creates a dependency.
  assign w_ld_haz = ex_mem_read & (ex_rt != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rt)) |
                     (id_use_rt & (id_rt == ex_rt)));

  assign w_br_tk  = ex_beq & ex_zero;

  // Mealy control decode and next-state selection.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_psd       = 1'b0;
    w_psc       = 1'b0;
    w_beq       = 1'b0;
    w_jump      = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;

    if (w_br_tk) begin
      // The branch is the oldest instruction in flight, so it wins in every
      // state and always (re)starts the flush window.
      w_beq    = 1'b1;
      w_flush  = 1'b1;
      w_bubble = 1'b1;
      if (BR_EXTRA > 0) begin
        w_nxt_state = BR_FLUSH;
        w_nxt_cnt   = c_BR_LOAD;
      end else begin
        w_nxt_state = RUN;
        w_nxt_cnt   = 3'd0;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (id_jump) begin
            // Single bubble: the fetched fall-through instruction is dropped
            // and the PC moves straight to the jump target.
            w_jump  = 1'b1;
            w_flush = 1'b1;
          end else if (w_ld_haz) begin
            w_psd    = 1'b1;
            w_bubble = 1'b1;
            if (LD_EXTRA > 0) begin
              w_nxt_state = LD_STALL;
              w_nxt_cnt   = c_LD_LOAD;
            end
          end
        end

        LD_STALL: begin
          // A jump waiting in ID is held until the stall has drained.
          w_psd    = 1'b1;
          w_bubble = 1'b1;
          if (r_cnt == 3'd0) begin
            w_nxt_state = RUN;
          end else begin
            w_nxt_cnt = r_cnt - 3'd1;
          end
        end

        BR_FLUSH: begin
          // Wrong-path instructions are being discarded, so their jumps and
          // load-use dependencies are meaningless here.
          w_psc    = 1'b1;
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (r_cnt == 3'd0) begin
            w_nxt_state = RUN;
          end else begin
            w_nxt_cnt = r_cnt - 3'd1;
          end
        end

        default: begin
          w_nxt_state = RUN;
          w_nxt_cnt   = 3'd0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign pc_sub_4_data = w_psd    & rst_n;
  assign pc_sub_4_ctrl = w_psc    & rst_n;
  assign beq           = w_beq    & rst_n;
  assign jump          = w_jump   & rst_n;
  assign if_id_flush   = w_flush  & rst_n;
  assign id_ex_bubble  = w_bubble & rst_n;

  assign w_stall_inc   = w_psd | w_psc;
  assign w_flush_inc   = w_flush;

  // FSM and extra-cycle down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != c_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != c_MAX)) begin
        r_flush_cnt <= r_flush_cnt + c_ONE;
      end
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                               |
// | Description : Self-checking bench for hazard_ctrl. Three instances with    |
// |               different parameter sets share one stimulus stream and are   |
// |               compared against a behavioural model every cycle.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_beq, ex_zero, id_jump, cnt_clr;

  logic [2:0] o_psd, o_psc, o_beq, o_jmp, o_flush, o_bub;
  logic [1:0] o_st0, o_st1, o_st2;
  logic [15:0] o_stc0, o_flc0, o_stc1, o_flc1;
  logic [3:0]  o_stc2, o_flc2;

  int n_checks = 0;
  int n_fail   = 0;

  // Parameter sets of the three instances.
  int P_LD[3] = '{0, 2, 5};
  int P_BR[3] = '{1, 0, 3};
  int P_W[3]  = '{16, 16, 4};

  // Model state: remaining extra stall / flush cycles, counter values.
  int m_ld[3], m_br[3], m_stc[3], m_flc[3];

  always #5 clk = ~clk;

  hazard_ctrl #(.LD_EXTRA(0), .BR_EXTRA(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_beq(ex_beq), .ex_zero(ex_zero), .id_jump(id_jump),
    .cnt_clr(cnt_clr), .pc_sub_4_data(o_psd[0]), .pc_sub_4_ctrl(o_psc[0]),
    .beq(o_beq[0]), .jump(o_jmp[0]), .if_id_flush(o_flush[0]),
    .id_ex_bubble(o_bub[0]), .state(o_st0), .stall_cnt(o_stc0), .flush_cnt(o_flc0));

  hazard_ctrl #(.LD_EXTRA(2), .BR_EXTRA(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_beq(ex_beq), .ex_zero(ex_zero), .id_jump(id_jump),
    .cnt_clr(cnt_clr), .pc_sub_4_data(o_psd[1]), .pc_sub_4_ctrl(o_psc[1]),
    .beq(o_beq[1]), .jump(o_jmp[1]), .if_id_flush(o_flush[1]),
    .id_ex_bubble(o_bub[1]), .state(o_st1), .stall_cnt(o_stc1), .flush_cnt(o_flc1));

  hazard_ctrl #(.LD_EXTRA(5), .BR_EXTRA(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_beq(ex_beq), .ex_zero(ex_zero), .id_jump(id_jump),
    .cnt_clr(cnt_clr), .pc_sub_4_data(o_psd[2]), .pc_sub_4_ctrl(o_psc[2]),
    .beq(o_beq[2]), .jump(o_jmp[2]), .if_id_flush(o_flush[2]),
    .id_ex_bubble(o_bub[2]), .state(o_st2), .stall_cnt(o_stc2), .flush_cnt(o_flc2));

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: actual %0h required %0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] act_ctl(int i);
    return {o_psd[i], o_psc[i], o_beq[i], o_jmp[i], o_flush[i], o_bub[i]};
  endfunction

  function automatic logic [31:0] act_state(int i);
    case (i)
      0:       return 32'(o_st0);
      1:       return 32'(o_st1);
      default: return 32'(o_st2);
    endcase
  endfunction

  function automatic logic [31:0] act_stc(int i);
    case (i)
      0:       return 32'(o_stc0);
      1:       return 32'(o_stc1);
      default: return 32'(o_stc2);
    endcase
  endfunction

  function automatic logic [31:0] act_flc(int i);
    case (i)
      0:       return 32'(o_flc0);
      1:       return 32'(o_flc1);
      default: return 32'(o_flc2);
    endcase
  endfunction

  // ------------------------------------------------------- reference model
  function automatic bit f_ld_haz();
    return ex_mem_read && (ex_rt != 0) &&
           ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
  endfunction

  // Controls as {psd, psc, beq, jump, flush, bubble}.
  function automatic logic [5:0] m_ctl(int i);
    if (!rst_n)                       return 6'b000000;
    if (ex_beq && ex_zero)            return 6'b001011;
    if (m_br[i] > 0)                  return 6'b010011;
    if (m_ld[i] > 0)                  return 6'b100001;
    if (id_jump)                      return 6'b000110;
    if (f_ld_haz())                   return 6'b100001;
    return 6'b000000;
  endfunction

  function automatic int m_state(int i);
    if (m_ld[i] > 0) return 1;
    if (m_br[i] > 0) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_ld[i] = 0; m_br[i] = 0; m_stc[i] = 0; m_flc[i] = 0;
    end
  endtask

  task automatic m_clock(int i);
    logic [5:0] c;
    int mx;
    if (!rst_n) begin
      m_ld[i] = 0; m_br[i] = 0; m_stc[i] = 0; m_flc[i] = 0;
      return;
    end
    c  = m_ctl(i);
    mx = (1 << P_W[i]) - 1;
    if (cnt_clr) begin
      m_stc[i] = 0;
      m_flc[i] = 0;
    end else begin
      if ((c[5] || c[4]) && m_stc[i] < mx) m_stc[i]++;
      if (c[1] && m_flc[i] < mx)           m_flc[i]++;
    end
    if (ex_beq && ex_zero) begin
      m_br[i] = P_BR[i];
      m_ld[i] = 0;
    end else if (m_br[i] > 0) begin
      m_br[i]--;
    end else if (m_ld[i] > 0) begin
      m_ld[i]--;
    end else if (!id_jump && f_ld_haz()) begin
      m_ld[i] = P_LD[i];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("ctl",       i, 32'(act_ctl(i)), 32'(m_ctl(i)));
      chk("state",     i, act_state(i),    32'(m_state(i)));
      chk("stall_cnt", i, act_stc(i),      32'(m_stc[i]));
      chk("flush_cnt", i, act_flc(i),      32'(m_flc[i]));
      chk("inv_psd_psc", i, 32'(o_psd[i] & o_psc[i]), 32'd0);
      chk("inv_beq_jmp", i, 32'(o_beq[i] & o_jmp[i]), 32'd0);
      chk("inv_beq_psc", i, 32'(o_beq[i] & o_psc[i]), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_clock(i);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic [4:0] xrt,
                       input logic xb, input logic xz, input logic jp, input logic clr);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_mem_read = mr; ex_rt = xrt; ex_beq = xb; ex_zero = xz;
    id_jump = jp; cnt_clr = clr;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld_use();
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    #3;
    compare_all();
    tick();
  endtask

  // -------------------------------------------------------- directed table
  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] xrt;
    logic       xb, xz, jp, clr;
    logic [5:0] ctl;   // expected controls of dut0 (LD_EXTRA=0, BR_EXTRA=1)
    logic [1:0] st;    // expected state of dut0
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic mr, logic [4:0] xrt, logic xb, logic xz,
                              logic jp, logic clr, logic [5:0] ctl, logic [1:0] st);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.xrt = xrt;
    v.xb = xb; v.xz = xz; v.jp = jp; v.clr = clr; v.ctl = ctl; v.st = st;
    return v;
  endfunction

  initial begin
    int exp_b_st[4];
    logic exp_b_psd[4];

    //                rs    rt    urs  urt  mr   xrt   xb   xz   jp   clr   ctl        st
    tbl[0]  = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1, 6'b000000, 2'd0); // clear
    tbl[1]  = mk(5'd8, 5'd0, 1'b1,1'b0,1'b1,5'd8, 1'b0,1'b0,1'b0,1'b0, 6'b100001, 2'd0); // rs load-use
    tbl[2]  = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b000000, 2'd0);
    tbl[3]  = mk(5'd0, 5'd0, 1'b1,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b000000, 2'd0); // load to $0
    tbl[4]  = mk(5'd3, 5'd5, 1'b0,1'b1,1'b1,5'd5, 1'b0,1'b0,1'b0,1'b0, 6'b100001, 2'd0); // rt load-use
    tbl[5]  = mk(5'd5, 5'd5, 1'b0,1'b0,1'b1,5'd5, 1'b0,1'b0,1'b0,1'b0, 6'b000000, 2'd0); // no use bits
    tbl[6]  = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0, 6'b001011, 2'd0); // taken branch
    tbl[7]  = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0, 6'b010011, 2'd2); // not-taken BEQ
    tbl[8]  = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b000000, 2'd0);
    tbl[9]  = mk(5'd8, 5'd0, 1'b1,1'b0,1'b1,5'd8, 1'b1,1'b1,1'b1,1'b0, 6'b001011, 2'd0); // all three
    tbl[10] = mk(5'd8, 5'd0, 1'b1,1'b0,1'b1,5'd8, 1'b0,1'b0,1'b1,1'b0, 6'b010011, 2'd2); // ignored in flush
    tbl[11] = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0, 6'b000110, 2'd0); // jump alone
    tbl[12] = mk(5'd8, 5'd0, 1'b1,1'b0,1'b1,5'd8, 1'b0,1'b0,1'b1,1'b0, 6'b000110, 2'd0); // jump beats ld
    tbl[13] = mk(5'd8, 5'd0, 1'b1,1'b0,1'b1,5'd8, 1'b1,1'b1,1'b0,1'b0, 6'b001011, 2'd0); // br beats ld
    tbl[14] = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0, 6'b001011, 2'd2); // br reload
    tbl[15] = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b010011, 2'd2);
    tbl[16] = mk(5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b000000, 2'd0);

    exp_b_st  = '{0, 1, 1, 0};
    exp_b_psd = '{1'b1, 1'b1, 1'b1, 1'b0};

    // ---- reset
    rst_n = 1'b0;
    idle();
    m_reset();
    @(posedge clk); #1;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- LD_EXTRA=2 stall length on dut1
    idle(); cnt_clr = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) ld_use(); else idle();
      #3;
      chk("ldx2_state", 1, act_state(1), 32'(exp_b_st[k]));
      chk("ldx2_psd",   1, 32'(o_psd[1]), 32'(exp_b_psd[k]));
      compare_all();
      tick();
    end
    chk("ldx2_stall_cnt", 1, act_stc(1), 32'd3);
    idle();
    for (int k = 0; k < 6; k++) step();

    // ---- directed table, dut0 expectations derived by hand
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].rs, tbl[k].rt, tbl[k].urs, tbl[k].urt, tbl[k].mr, tbl[k].xrt,
            tbl[k].xb, tbl[k].xz, tbl[k].jp, tbl[k].clr);
      #3;
      chk($sformatf("tbl%0d_ctl", k), 0, 32'(act_ctl(0)), 32'(tbl[k].ctl));
      chk($sformatf("tbl%0d_state", k), 0, act_state(0), 32'(tbl[k].st));
      compare_all();
      tick();
    end
    chk("tbl_stall_cnt", 0, act_stc(0), 32'd5);
    chk("tbl_flush_cnt", 0, act_flc(0), 32'd9);
    idle();
    for (int k = 0; k < 4; k++) step();

    // ---- asynchronous reset in the middle of a LD_EXTRA=5 stall on dut2
    ld_use();
    step();
    idle();
    #3;
    chk("pre_rst_state", 2, act_state(2), 32'd1);
    compare_all();
    tick();
    ld_use();
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_ctl",   2, 32'(act_ctl(2)), 32'd0);
    chk("rst_state", 2, act_state(2),    32'd0);
    chk("rst_stc",   2, act_stc(2),      32'd0);
    compare_all();
    tick();
    rst_n = 1'b1;
    ld_use();
    #3;
    chk("fresh_ctl", 2, 32'(act_ctl(2)), 32'(6'b100001));
    chk("fresh_state", 2, act_state(2), 32'd0);
    compare_all();
    tick();
    idle();
    for (int k = 0; k < 6; k++) step();

    // ---- saturation on dut2 (4-bit counters) and clear-over-increment
    ld_use();
    for (int k = 0; k < 20; k++) step();
    chk("sat_stall_cnt", 2, act_stc(2), 32'd15);
    cnt_clr = 1'b1;
    #3;
    chk("clr_cycle_psd", 2, 32'(o_psd[2]), 32'd1);
    compare_all();
    tick();
    cnt_clr = 1'b0;
    #1;
    chk("clr_stall_cnt", 2, act_stc(2), 32'd0);
    idle();
    for (int k = 0; k < 6; k++) step();

    // ---- randomized stimulus against the model
    for (int k = 0; k < 400; k++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It is the producer side of the next-PC select interface.
- Detects load-use data hazards in ID and taken branches resolved in EX, and services jumps decoded in ID.
- Drives the PC-select controls (pc_sub_4_data, pc_sub_4_ctrl, beq, jump) consumed by the next-PC mux, plus the IF/ID flush and ID/EX bubble controls.
- Keeps multi-cycle stall/flush state and saturating performance counters.

Parameters:
- LD_EXTRA, 0: extra load-use stall cycles after the first; legal 0..7.
- BR_EXTRA, 1: extra flush cycles after a taken branch; legal 0..7.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- ex_beq  in  1  instruction in EX is a BEQ.
- ex_zero  in  1  ALU zero flag in EX.
- id_jump  in  1  instruction in ID is a J.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_sub_4_data  out  1  re-fetch the current PC (data bubble).
- pc_sub_4_ctrl  out  1  re-fetch the current PC (control bubble).
- beq  out  1  select the branch target.
- jump  out  1  select the jump target.
- if_id_flush  out  1  zero the IF/ID register.
- id_ex_bubble  out  1  inject a NOP into ID/EX.
- state  out  2  FSM state: RUN=0, LD_STALL=1, BR_FLUSH=2.
- stall_cnt  out  CNT_W  count of cycles with either pc_sub_4 output high.
- flush_cnt  out  CNT_W  count of cycles with if_id_flush high.

Behaviour:
Definitions:
- ld_haz = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
- br_tk = ex_beq & ex_zero.

FSM and counters:
- The FSM and counters are registered. Control outputs are Mealy: a combinational function of state, the internal 3-bit down-counter cnt, and the current inputs.
- Reset, asynchronous, any time including mid-stall: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0. All control outputs are 0 while rst_n=0.

Event priority, in every state:
- br_tk is highest: the branch is the oldest instruction and overrides everything.
- Then id_jump.
- Then ld_haz.

RUN:
- br_tk: beq=1, if_id_flush=1, id_ex_bubble=1. If BR_EXTRA>0, next state is BR_FLUSH with cnt=BR_EXTRA-1; otherwise stay in RUN.
- else id_jump: jump=1, if_id_flush=1. Stay in RUN. This is a single bubble, with no pc_sub_4.
- else ld_haz: pc_sub_4_data=1, id_ex_bubble=1. If LD_EXTRA>0, next state is LD_STALL with cnt=LD_EXTRA-1; otherwise stay in RUN.
- else: all control outputs 0.

LD_STALL:
- pc_sub_4_data=1, id_ex_bubble=1.
- When cnt==0, next state is RUN; otherwise decrement cnt.
- id_jump is ignored; it is serviced in RUN once the stall ends.
- br_tk aborts the stall: outputs and next state are exactly as for RUN with br_tk, and pc_sub_4_data=0.

BR_FLUSH:
- pc_sub_4_ctrl=1, if_id_flush=1, id_ex_bubble=1, beq=0.
- id_jump and ld_haz are ignored.
- When cnt==0, next state is RUN; otherwise decrement cnt.
- A new br_tk reloads cnt=BR_EXTRA-1, with beq=1 and pc_sub_4_ctrl=0 in that cycle.

Invariants:
- pc_sub_4_data and pc_sub_4_ctrl are never both 1.
- beq and jump are never both 1.
- beq=1 implies pc_sub_4_ctrl=0.

Counters:
- Increment on the rising edge when their condition held in that cycle.
- Saturate at all-ones; no wrap.
- cnt_clr takes priority over increment.
- Fixed latency: a hazard is flagged in the same cycle the inputs present it. No pipeline delay.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1, LD_EXTRA=0 -> exactly one cycle of pc_sub_4_data=1 and id_ex_bubble=1; state stays 0; stall_cnt=1.
- Load to $0: same stimulus with ex_rt=0 -> no stall, all controls 0. Then LD_EXTRA=2 with ex_rt=8 -> three consecutive stall cycles, state 1 for two cycles, stall_cnt=3.
- Taken branch: ex_beq=1, ex_zero=1, BR_EXTRA=1 -> cycle 0: beq=1, if_id_flush=1. Cycle 1: state=2, pc_sub_4_ctrl=1, beq=0. Cycle 2: RUN. flush_cnt=2.
- Simultaneous events: br_tk, id_jump and ld_haz all high in RUN -> only beq=1; jump=0 and pc_sub_4_data=0. Then id_jump alone -> jump=1, if_id_flush=1, pc_sub_4_ctrl=0.
- Reset mid-stall: LD_EXTRA=5, deassert rst_n at state=1 -> outputs 0 immediately without a clock, and state=0, counters=0. Next hazard behaves as fresh.
- Counter saturation and clear: CNT_W=4, hold ld_haz for 20 cycles -> stall_cnt sticks at 15. cnt_clr and increment in the same cycle -> 0.
